// File: rtl/pipeline_scheduler.sv
// Stall/flush sequencer for the 5-stage pipeline: merges hazard requests with memory
// wait states, multi-cycle multiply and interrupt entry. Optional PIPE_PERF_CNT_EN adds perf counters.
module pipeline_scheduler #(
   parameter int MUL_LATENCY = 4,
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load_use,
   input  logic             i_branch_taken,
   input  logic             i_jump,
   input  logic             i_EX_mul,
   input  logic             i_MEM_req,
   input  logic             i_mem_ready,
   input  logic             i_irq,
   output logic             o_pc_keep,
   output logic             o_IF_ID_keep,
   output logic             o_ID_EX_keep,
   output logic             o_EX_MEM_keep,
   output logic             o_IF_ID_flush,
   output logic             o_ID_EX_flush,
   output logic             o_EX_MEM_flush,
   output logic             o_MEM_WB_flush,
   output logic             o_irq_ack,
   output logic             o_mem_timeout,
   output logic [1:0]       o_state,
   output logic [CNT_W-1:0] o_stall_cnt,
   output logic [CNT_W-1:0] o_flush_cnt
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      MUL_WAIT = 2'd2
   } state_t;

   typedef struct packed {
      logic pc_keep;
      logic if_id_keep;
      logic id_ex_keep;
      logic ex_mem_keep;
      logic if_id_flush;
      logic id_ex_flush;
      logic ex_mem_flush;
      logic mem_wb_flush;
      logic irq_ack;
   } ctl_t;

   localparam ctl_t CTL_NONE      = '0;
   localparam ctl_t CTL_MEM_STALL = '{pc_keep: 1'b1, if_id_keep: 1'b1, id_ex_keep: 1'b1,
                                      ex_mem_keep: 1'b1, mem_wb_flush: 1'b1, default: 1'b0};
   localparam ctl_t CTL_MUL_STALL = '{pc_keep: 1'b1, if_id_keep: 1'b1, id_ex_keep: 1'b1,
                                      ex_mem_flush: 1'b1, default: 1'b0};
   localparam ctl_t CTL_BRANCH    = '{if_id_flush: 1'b1, id_ex_flush: 1'b1, default: 1'b0};
   localparam ctl_t CTL_LOAD_USE  = '{pc_keep: 1'b1, if_id_keep: 1'b1, id_ex_flush: 1'b1,
                                      default: 1'b0};
   localparam ctl_t CTL_JUMP      = '{if_id_flush: 1'b1, default: 1'b0};
   localparam ctl_t CTL_IRQ       = '{irq_ack: 1'b1, if_id_flush: 1'b1, id_ex_flush: 1'b1,
                                      default: 1'b0};

   localparam logic [3:0] MUL_RELOAD = 4'(MUL_LATENCY - 1);
   localparam logic [7:0] MEM_LIMIT  = 8'(MEM_TIMEOUT);

   state_t     state, state_d;
   logic [3:0] mul_cnt, mul_cnt_d;
   logic [7:0] mem_cnt, mem_cnt_d;
   logic       irq_armed, irq_armed_d;
   logic       timeout, timeout_d;
   ctl_t       ctl;
   logic       do_eval, allow_mem, allow_mul;

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      ctl         = CTL_NONE;
      state_d     = state;
      mul_cnt_d   = mul_cnt;
      mem_cnt_d   = mem_cnt;
      irq_armed_d = irq_armed | ~i_irq;
      timeout_d   = timeout;
      do_eval     = 1'b0;
      allow_mem   = 1'b0;
      allow_mul   = 1'b0;

      case (state)
         RUN: begin
            do_eval   = 1'b1;
            allow_mem = 1'b1;
            allow_mul = 1'b1;
         end
         MEM_WAIT: begin
            mem_cnt_d = (mem_cnt == 8'hFF) ? mem_cnt : mem_cnt + 8'd1;
            if (i_mem_ready || mem_cnt == MEM_LIMIT) begin
               // Release cycle; on timeout the access is dropped and the flag latches.
               do_eval   = 1'b1;
               allow_mul = 1'b1;
               state_d   = RUN;
               if (!i_mem_ready) timeout_d = 1'b1;
            end else begin
               ctl = CTL_MEM_STALL;
            end
         end
         MUL_WAIT: begin
            if (mul_cnt != 4'd0) begin
               ctl       = CTL_MUL_STALL;
               mul_cnt_d = mul_cnt - 4'd1;
            end else begin
               do_eval = 1'b1;
               state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase

      if (do_eval) begin
         if (allow_mem && i_MEM_req && !i_mem_ready) begin
            ctl       = CTL_MEM_STALL;
            state_d   = MEM_WAIT;
            mem_cnt_d = 8'd1;
         end else if (allow_mul && i_EX_mul) begin
            ctl       = CTL_MUL_STALL;
            mul_cnt_d = MUL_RELOAD;
            state_d   = MUL_WAIT;
         end else if (i_branch_taken) begin
            ctl = CTL_BRANCH;
         end else if (i_load_use) begin
            ctl = CTL_LOAD_USE;
         end else if (i_jump) begin
            ctl = CTL_JUMP;
         end else if (i_irq && irq_armed) begin
            ctl         = CTL_IRQ;
            irq_armed_d = 1'b0;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= RUN;
         mul_cnt   <= '0;
         mem_cnt   <= '0;
         irq_armed <= 1'b1;
         timeout   <= 1'b0;
      end else begin
         state     <= state_d;
         mul_cnt   <= mul_cnt_d;
         mem_cnt   <= mem_cnt_d;
         irq_armed <= irq_armed_d;
         timeout   <= timeout_d;
      end
   end

   // Controls are Mealy, so they are gated by reset to stay quiet while it is held.
   assign o_pc_keep      = i_rst_n & ctl.pc_keep;
   assign o_IF_ID_keep   = i_rst_n & ctl.if_id_keep;
   assign o_ID_EX_keep   = i_rst_n & ctl.id_ex_keep;
   assign o_EX_MEM_keep  = i_rst_n & ctl.ex_mem_keep;
   assign o_IF_ID_flush  = i_rst_n & ctl.if_id_flush;
   assign o_ID_EX_flush  = i_rst_n & ctl.id_ex_flush;
   assign o_EX_MEM_flush = i_rst_n & ctl.ex_mem_flush;
   assign o_MEM_WB_flush = i_rst_n & ctl.mem_wb_flush;
   assign o_irq_ack      = i_rst_n & ctl.irq_ack;
   assign o_mem_timeout  = timeout;
   assign o_state        = state;

`ifdef PIPE_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (o_pc_keep && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
         if (o_IF_ID_flush && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

   assign o_stall_cnt = stall_cnt;
   assign o_flush_cnt = flush_cnt;
`else
   assign o_stall_cnt = '0;
   assign o_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_scheduler.sv
// Directed bench for pipeline_scheduler: hazard priority, multiply and memory stalls,
// memory timeout, interrupt acknowledge and reset behaviour.
module tb_pipeline_scheduler;

   localparam int CNT_W = 32;

   // Control vector order: pc_keep, IF_ID_keep, ID_EX_keep, EX_MEM_keep,
   // IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush, irq_ack
   localparam logic [8:0] C_NONE = 9'b000000000;
   localparam logic [8:0] C_MEM  = 9'b111100010;
   localparam logic [8:0] C_MUL  = 9'b111000100;
   localparam logic [8:0] C_BR   = 9'b000011000;
   localparam logic [8:0] C_LU   = 9'b110001000;
   localparam logic [8:0] C_JMP  = 9'b000010000;
   localparam logic [8:0] C_IRQ  = 9'b000011001;

   // Input vector order: load_use, branch_taken, jump, EX_mul, MEM_req, mem_ready, irq
   localparam logic [6:0] I_NONE = 7'b0000000;
   localparam logic [6:0] I_LU   = 7'b1000000;
   localparam logic [6:0] I_BR   = 7'b0100000;
   localparam logic [6:0] I_JMP  = 7'b0010000;
   localparam logic [6:0] I_MUL  = 7'b0001000;
   localparam logic [6:0] I_REQ  = 7'b0000100;
   localparam logic [6:0] I_RDY  = 7'b0000010;
   localparam logic [6:0] I_IRQ  = 7'b0000001;

   logic             i_clk = 1'b0;
   logic             i_rst_n = 1'b0;
   logic             i_load_use, i_branch_taken, i_jump, i_EX_mul, i_MEM_req, i_mem_ready, i_irq;
   logic             o_pc_keep, o_IF_ID_keep, o_ID_EX_keep, o_EX_MEM_keep;
   logic             o_IF_ID_flush, o_ID_EX_flush, o_EX_MEM_flush, o_MEM_WB_flush;
   logic             o_irq_ack, o_mem_timeout;
   logic [1:0]       o_state;
   logic [CNT_W-1:0] o_stall_cnt, o_flush_cnt;
   logic [8:0]       ctl;

   int n_cmp = 0;
   int n_err = 0;
   int exp_stall = 0;
   int exp_flush = 0;

   always #5 i_clk = ~i_clk;

   pipeline_scheduler #(
      .MUL_LATENCY(4),
      .MEM_TIMEOUT(64),
      .CNT_W(CNT_W)
   ) dut (
      .i_clk          (i_clk),
      .i_rst_n        (i_rst_n),
      .i_load_use     (i_load_use),
      .i_branch_taken (i_branch_taken),
      .i_jump         (i_jump),
      .i_EX_mul       (i_EX_mul),
      .i_MEM_req      (i_MEM_req),
      .i_mem_ready    (i_mem_ready),
      .i_irq          (i_irq),
      .o_pc_keep      (o_pc_keep),
      .o_IF_ID_keep   (o_IF_ID_keep),
      .o_ID_EX_keep   (o_ID_EX_keep),
      .o_EX_MEM_keep  (o_EX_MEM_keep),
      .o_IF_ID_flush  (o_IF_ID_flush),
      .o_ID_EX_flush  (o_ID_EX_flush),
      .o_EX_MEM_flush (o_EX_MEM_flush),
      .o_MEM_WB_flush (o_MEM_WB_flush),
      .o_irq_ack      (o_irq_ack),
      .o_mem_timeout  (o_mem_timeout),
      .o_state        (o_state),
      .o_stall_cnt    (o_stall_cnt),
      .o_flush_cnt    (o_flush_cnt)
   );

   assign ctl = {o_pc_keep, o_IF_ID_keep, o_ID_EX_keep, o_EX_MEM_keep,
                 o_IF_ID_flush, o_ID_EX_flush, o_EX_MEM_flush, o_MEM_WB_flush, o_irq_ack};

   function automatic logic [CNT_W-1:0] want_stall_cnt();
`ifdef PIPE_PERF_CNT_EN
      return CNT_W'(exp_stall);
`else
      return '0;
`endif
   endfunction

   function automatic logic [CNT_W-1:0] want_flush_cnt();
`ifdef PIPE_PERF_CNT_EN
      return CNT_W'(exp_flush);
`else
      return '0;
`endif
   endfunction

   task automatic drive(input logic [6:0] v);
      {i_load_use, i_branch_taken, i_jump, i_EX_mul, i_MEM_req, i_mem_ready, i_irq} = v;
   endtask

   // Advance one cycle, crediting the expected counters with this cycle's expected controls.
   task automatic tick(input logic [8:0] e);
      if (e[8]) exp_stall++;
      if (e[4]) exp_flush++;
      @(posedge i_clk);
      #1;
   endtask

   task automatic test_reset();
      drive(I_LU | I_REQ | I_IRQ | I_MUL | I_BR);
      #3;
      n_cmp++;
      if (ctl !== C_NONE || o_state !== 2'd0 || o_mem_timeout !== 1'b0) begin
         n_err++;
         $display("FAIL reset_hold: ctl=%b state=%0d timeout=%b, want ctl=%b state=0 timeout=0",
                  ctl, o_state, o_mem_timeout, C_NONE);
      end
      n_cmp++;
      if (o_stall_cnt !== '0 || o_flush_cnt !== '0) begin
         n_err++;
         $display("FAIL reset_cnt: stall=%0d flush=%0d, want 0/0", o_stall_cnt, o_flush_cnt);
      end
      repeat (2) @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      exp_stall = 0;
      exp_flush = 0;
      // irq_armed comes out of reset set, so a first-cycle interrupt is acknowledged
      drive(I_IRQ);
      @(negedge i_clk);
      n_cmp++;
      if (ctl !== C_IRQ || o_state !== 2'd0) begin
         n_err++;
         $display("FAIL reset_irq_armed: ctl=%b state=%0d, want ctl=%b state=0", ctl, o_state, C_IRQ);
      end
      tick(C_IRQ);
      drive(I_NONE);
      @(negedge i_clk);
      n_cmp++;
      if (ctl !== C_NONE || o_state !== 2'd0) begin
         n_err++;
         $display("FAIL reset_idle: ctl=%b state=%0d, want ctl=%b state=0", ctl, o_state, C_NONE);
      end
      tick(C_NONE);
   endtask

   task automatic test_load_use();
      logic [6:0] vin [3];
      logic [8:0] vexp [3];
      vin  = '{I_NONE, I_LU, I_NONE};
      vexp = '{C_NONE, C_LU, C_NONE};
      for (int i = 0; i < 3; i++) begin
         drive(vin[i]);
         @(negedge i_clk);
         n_cmp++;
         if (ctl !== vexp[i] || o_state !== 2'd0) begin
            n_err++;
            $display("FAIL load_use[%0d]: ctl=%b state=%0d, want ctl=%b state=0", i, ctl, o_state, vexp[i]);
         end
         tick(vexp[i]);
      end
   endtask

   task automatic test_priority();
      logic [6:0] vin [7];
      logic [8:0] vexp [7];
      vin  = '{I_BR | I_LU, I_JMP | I_LU, I_JMP, I_BR | I_IRQ, I_JMP | I_IRQ,
               I_REQ | I_RDY | I_IRQ, I_NONE};
      vexp = '{C_BR, C_LU, C_JMP, C_BR, C_JMP, C_IRQ, C_NONE};
      for (int i = 0; i < 7; i++) begin
         drive(vin[i]);
         @(negedge i_clk);
         n_cmp++;
         if (ctl !== vexp[i] || o_state !== 2'd0) begin
            n_err++;
            $display("FAIL priority[%0d]: ctl=%b state=%0d, want ctl=%b state=0", i, ctl, o_state, vexp[i]);
         end
         tick(vexp[i]);
      end
   endtask

   task automatic test_mul();
      logic [6:0] vin [6];
      logic [8:0] vexp [6];
      logic [1:0] vst [6];
      // A memory request during MUL_WAIT must be ignored
      vin  = '{I_MUL, I_MUL, I_MUL | I_REQ, I_MUL, I_MUL, I_NONE};
      vexp = '{C_MUL, C_MUL, C_MUL, C_MUL, C_NONE, C_NONE};
      vst  = '{2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
      for (int i = 0; i < 6; i++) begin
         drive(vin[i]);
         @(negedge i_clk);
         n_cmp++;
         if (ctl !== vexp[i] || o_state !== vst[i]) begin
            n_err++;
            $display("FAIL mul[%0d]: ctl=%b state=%0d, want ctl=%b state=%0d", i, ctl, o_state, vexp[i], vst[i]);
         end
         tick(vexp[i]);
      end
   endtask

   task automatic test_mem_wait();
      logic [6:0] vin [5];
      logic [8:0] vexp [5];
      logic [1:0] vst [5];
      vin  = '{I_REQ | I_LU, I_REQ, I_REQ, I_REQ | I_RDY | I_BR, I_NONE};
      vexp = '{C_MEM, C_MEM, C_MEM, C_BR, C_NONE};
      vst  = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
      for (int i = 0; i < 5; i++) begin
         drive(vin[i]);
         @(negedge i_clk);
         n_cmp++;
         if (ctl !== vexp[i] || o_state !== vst[i]) begin
            n_err++;
            $display("FAIL mem_wait[%0d]: ctl=%b state=%0d, want ctl=%b state=%0d", i, ctl, o_state, vexp[i], vst[i]);
         end
         tick(vexp[i]);
      end
      n_cmp++;
      if (o_mem_timeout !== 1'b0) begin
         n_err++;
         $display("FAIL mem_wait_timeout: timeout=%b, want 0", o_mem_timeout);
      end
   endtask

   task automatic test_mem_to_mul();
      logic [6:0] vin [7];
      logic [8:0] vexp [7];
      logic [1:0] vst [7];
      vin  = '{I_REQ, I_RDY | I_MUL, I_MUL, I_MUL, I_MUL, I_MUL, I_NONE};
      vexp = '{C_MEM, C_MUL, C_MUL, C_MUL, C_MUL, C_NONE, C_NONE};
      vst  = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
      for (int i = 0; i < 7; i++) begin
         drive(vin[i]);
         @(negedge i_clk);
         n_cmp++;
         if (ctl !== vexp[i] || o_state !== vst[i]) begin
            n_err++;
            $display("FAIL mem_to_mul[%0d]: ctl=%b state=%0d, want ctl=%b state=%0d", i, ctl, o_state, vexp[i], vst[i]);
         end
         tick(vexp[i]);
      end
   endtask

   task automatic test_irq();
      int acks = 0;
      logic [8:0] e;
      for (int i = 0; i < 10; i++) begin
         drive(I_IRQ);
         @(negedge i_clk);
         e = (i == 0) ? C_IRQ : C_NONE;
         if (o_irq_ack === 1'b1) acks++;
         n_cmp++;
         if (ctl !== e) begin
            n_err++;
            $display("FAIL irq_hold[%0d]: ctl=%b, want %b", i, ctl, e);
         end
         tick(e);
      end
      n_cmp++;
      if (acks != 1) begin
         n_err++;
         $display("FAIL irq_ack_count: got %0d acks, want 1", acks);
      end
      drive(I_NONE);
      @(negedge i_clk);
      tick(C_NONE);
      drive(I_IRQ);
      @(negedge i_clk);
      n_cmp++;
      if (ctl !== C_IRQ) begin
         n_err++;
         $display("FAIL irq_rearm: ctl=%b, want %b", ctl, C_IRQ);
      end
      tick(C_IRQ);
      drive(I_NONE);
      @(negedge i_clk);
      tick(C_NONE);
   endtask

   task automatic test_timeout();
      int stalls = 0;
      drive(I_REQ);
      @(negedge i_clk);
      if (ctl === C_MEM) stalls++;
      tick(C_MEM);
      drive(I_NONE);
      for (int i = 0; i < 100; i++) begin
         @(negedge i_clk);
         if (ctl !== C_MEM) break;
         stalls++;
         tick(C_MEM);
      end
      n_cmp++;
      if (stalls != 64) begin
         n_err++;
         $display("FAIL timeout_stalls: got %0d stalled cycles, want 64", stalls);
      end
      n_cmp++;
      if (ctl !== C_NONE || o_state !== 2'd1 || o_mem_timeout !== 1'b0) begin
         n_err++;
         $display("FAIL timeout_release: ctl=%b state=%0d timeout=%b, want ctl=%b state=1 timeout=0",
                  ctl, o_state, o_mem_timeout, C_NONE);
      end
      tick(C_NONE);
      for (int i = 0; i < 3; i++) begin
         @(negedge i_clk);
         n_cmp++;
         if (o_mem_timeout !== 1'b1 || o_state !== 2'd0 || ctl !== C_NONE) begin
            n_err++;
            $display("FAIL timeout_sticky[%0d]: timeout=%b state=%0d ctl=%b, want 1/0/%b",
                     i, o_mem_timeout, o_state, ctl, C_NONE);
         end
         tick(C_NONE);
      end
      @(negedge i_clk);
      n_cmp++;
      if (o_stall_cnt !== want_stall_cnt() || o_flush_cnt !== want_flush_cnt()) begin
         n_err++;
         $display("FAIL perf_cnt: stall=%0d flush=%0d, want %0d/%0d",
                  o_stall_cnt, o_flush_cnt, want_stall_cnt(), want_flush_cnt());
      end
      tick(C_NONE);
   endtask

   task automatic test_reset_mid_mul();
      drive(I_MUL);
      @(negedge i_clk);
      n_cmp++;
      if (ctl !== C_MUL || o_state !== 2'd0) begin
         n_err++;
         $display("FAIL rst_mul_start: ctl=%b state=%0d, want ctl=%b state=0", ctl, o_state, C_MUL);
      end
      tick(C_MUL);
      @(negedge i_clk);
      n_cmp++;
      if (ctl !== C_MUL || o_state !== 2'd2) begin
         n_err++;
         $display("FAIL rst_mul_wait: ctl=%b state=%0d, want ctl=%b state=2", ctl, o_state, C_MUL);
      end
      i_rst_n = 1'b0;
      exp_stall = 0;
      exp_flush = 0;
      #1;
      n_cmp++;
      if (ctl !== C_NONE || o_state !== 2'd0 || o_mem_timeout !== 1'b0) begin
         n_err++;
         $display("FAIL rst_mid_mul: ctl=%b state=%0d timeout=%b, want ctl=%b state=0 timeout=0",
                  ctl, o_state, o_mem_timeout, C_NONE);
      end
      n_cmp++;
      if (o_stall_cnt !== '0 || o_flush_cnt !== '0) begin
         n_err++;
         $display("FAIL rst_mid_cnt: stall=%0d flush=%0d, want 0/0", o_stall_cnt, o_flush_cnt);
      end
      @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      drive(I_NONE);
      @(negedge i_clk);
      n_cmp++;
      if (ctl !== C_NONE || o_state !== 2'd0) begin
         n_err++;
         $display("FAIL rst_resume: ctl=%b state=%0d, want ctl=%b state=0", ctl, o_state, C_NONE);
      end
      tick(C_NONE);
      drive(I_LU);
      @(negedge i_clk);
      n_cmp++;
      if (ctl !== C_LU || o_state !== 2'd0) begin
         n_err++;
         $display("FAIL rst_resume_lu: ctl=%b state=%0d, want ctl=%b state=0", ctl, o_state, C_LU);
      end
      tick(C_LU);
      drive(I_NONE);
      @(negedge i_clk);
      n_cmp++;
      if (o_stall_cnt !== want_stall_cnt() || o_flush_cnt !== want_flush_cnt()) begin
         n_err++;
         $display("FAIL rst_resume_cnt: stall=%0d flush=%0d, want %0d/%0d",
                  o_stall_cnt, o_flush_cnt, want_stall_cnt(), want_flush_cnt());
      end
      tick(C_NONE);
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_priority();
      test_mul();
      test_mem_wait();
      test_mem_to_mul();
      test_irq();
      test_timeout();
      test_reset_mid_mul();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded 200000 time units, want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
